// File: rtl/router_reg_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_reg_if : source/FSM inputs and FIFO-side outputs of router_reg  |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
interface router_reg_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_packet_valid;
  logic       err;
  logic       len_err;
  logic [7:0] err_count;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, len_err, err_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, len_err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/router_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_reg : router datapath - header/byte latching, parity and length |
// | checking, saturating error counter.            Revision 1.0            |
// +-----------------------------------------------------------------------+
module router_reg (
  input  logic          clock,
  input  logic          reset,
  router_reg_if.slave   bus
);

  logic [7:0] header_q,    header_d;
  logic [7:0] full_byte_q, full_byte_d;
  logic [7:0] dout_q,      dout_d;
  logic [7:0] int_par_q,   int_par_d;
  logic [7:0] pkt_par_q,   pkt_par_d;
  logic       pd_q,        pd_d;
  logic       lpv_q,       lpv_d;
  logic [5:0] cnt_q,       cnt_d;
  logic       err_q,       err_d;
  logic       len_err_q,   len_err_d;
  logic       rst_int_q,   rst_int_d;
  logic [7:0] err_cnt_q,   err_cnt_d;
  logic       w_hdr_ok;

  // Address 2'b11 is not a valid destination; such a header leaves state alone.
  assign w_hdr_ok = !(bus.pkt_valid && (bus.data_in[1:0] == 2'b11));

  always_comb begin
    header_d    = header_q;
    full_byte_d = full_byte_q;
    dout_d      = dout_q;
    int_par_d   = int_par_q;
    pkt_par_d   = pkt_par_q;
    pd_d        = pd_q;
    lpv_d       = lpv_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    len_err_d   = len_err_q;
    rst_int_d   = bus.rst_int_reg;
    err_cnt_d   = err_cnt_q;

    if (bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11))
      header_d = bus.data_in;

    if (bus.ld_state && bus.fifo_full)
      full_byte_d = bus.data_in;

    if (bus.full_state)
      dout_d = dout_q;
    else if (bus.lfd_state)
      dout_d = header_q;
    else if (bus.ld_state && !bus.fifo_full)
      dout_d = bus.data_in;
    else if (bus.laf_state)
      dout_d = full_byte_q;

    if (bus.detect_add) begin
      if (w_hdr_ok)
        int_par_d = 8'h00;
    end else if (bus.lfd_state)
      int_par_d = int_par_q ^ header_q;
    else if (bus.ld_state && bus.pkt_valid)
      int_par_d = int_par_q ^ bus.data_in;

    if (bus.ld_state && !bus.pkt_valid)
      pkt_par_d = bus.data_in;

    // A parity byte blocked by fifo_full is only complete once laf drains it.
    if (bus.detect_add)
      pd_d = 1'b0;
    else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
             (bus.laf_state && lpv_q && !pd_q))
      pd_d = 1'b1;

    if (bus.rst_int_reg)
      lpv_d = 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      lpv_d = 1'b1;

    if (bus.lfd_state)
      cnt_d = 6'd0;
    else if (bus.ld_state && bus.pkt_valid && (cnt_q != 6'd63))
      cnt_d = cnt_q + 6'd1;

    if (bus.rst_int_reg) begin
      err_d     = (int_par_q != pkt_par_q);
      len_err_d = (cnt_q != header_q[7:2]);
    end else if (bus.detect_add && bus.pkt_valid) begin
      err_d     = 1'b0;
      len_err_d = 1'b0;
    end

    // err/len_err settle on the rst_int_reg edge, so they are counted one cycle later.
    if (rst_int_q && (err_q || len_err_q) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      header_q    <= 8'h00;
      full_byte_q <= 8'h00;
      dout_q      <= 8'h00;
      int_par_q   <= 8'h00;
      pkt_par_q   <= 8'h00;
      pd_q        <= 1'b0;
      lpv_q       <= 1'b0;
      cnt_q       <= 6'd0;
      err_q       <= 1'b0;
      len_err_q   <= 1'b0;
      rst_int_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      header_q    <= header_d;
      full_byte_q <= full_byte_d;
      dout_q      <= dout_d;
      int_par_q   <= int_par_d;
      pkt_par_q   <= pkt_par_d;
      pd_q        <= pd_d;
      lpv_q       <= lpv_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      len_err_q   <= len_err_d;
      rst_int_q   <= rst_int_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = pd_q;
  assign bus.low_packet_valid = lpv_q;
  assign bus.err              = err_q;
  assign bus.len_err          = len_err_q;
  assign bus.err_count        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_router_reg : directed self-checking bench for router_reg            |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_router_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  router_reg_if bus ();
  router_reg u_dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock: apply decodes/inputs, wait for the edge, settle 1 time unit.
  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic ri, input logic pv,
                       input logic [7:0] d, input logic ff);
    bus.detect_add  = da;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fs;
    bus.rst_int_reg = ri;
    bus.pkt_valid   = pv;
    bus.data_in     = d;
    bus.fifo_full   = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] pl, input int n,
                          input logic [7:0] par);
    drive(1, 0, 0, 0, 0, 0, 1, hdr, 0);
    drive(0, 1, 0, 0, 0, 0, 1, pl[7:0], 0);
    for (int i = 0; i < n; i++)
      drive(0, 0, 1, 0, 0, 0, 1, pl[8*i +: 8], 0);
    drive(0, 0, 1, 0, 0, 0, 0, par, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    idle();
  endtask

  initial begin
    bus.detect_add = 0; bus.lfd_state = 0; bus.ld_state = 0; bus.laf_state = 0;
    bus.full_state = 0; bus.rst_int_reg = 0; bus.pkt_valid = 0;
    bus.data_in = 8'h00; bus.fifo_full = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_pd", {7'd0, bus.parity_done}, 8'h00);
    chk("rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
    chk("rst_err", {7'd0, bus.err}, 8'h00);
    chk("rst_len_err", {7'd0, bus.len_err}, 8'h00);
    chk("rst_err_count", bus.err_count, 8'h00);
    rst = 1'b0;
    idle();

    // Good packet: hdr 0D (len 3, addr 1), payload 11 22 33, parity 0D
    drive(1, 0, 0, 0, 0, 0, 1, 8'h0D, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h11, 0);
    chk("p1_dout_hdr", bus.dout, 8'h0D);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11, 0);
    chk("p1_dout_b0", bus.dout, 8'h11);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h22, 0);
    chk("p1_dout_b1", bus.dout, 8'h22);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h33, 0);
    chk("p1_dout_b2", bus.dout, 8'h33);
    chk("p1_pd_early", {7'd0, bus.parity_done}, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h0D, 0);
    chk("p1_pd", {7'd0, bus.parity_done}, 8'h01);
    chk("p1_lpv_set", {7'd0, bus.low_packet_valid}, 8'h01);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    chk("p1_err", {7'd0, bus.err}, 8'h00);
    chk("p1_len_err", {7'd0, bus.len_err}, 8'h00);
    chk("p1_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);
    idle();
    chk("p1_err_count", bus.err_count, 8'h00);

    // Same packet with bad parity byte
    send_pkt(8'h0D, 32'h0033_2211, 3, 8'hFF);
    chk("p2_err", {7'd0, bus.err}, 8'h01);
    chk("p2_len_err", {7'd0, bus.len_err}, 8'h00);
    chk("p2_err_count", bus.err_count, 8'h01);
    idle();
    chk("p2_err_hold", {7'd0, bus.err}, 8'h01);
    drive(1, 0, 0, 0, 0, 0, 1, 8'h11, 0);
    chk("p2_err_clr", {7'd0, bus.err}, 8'h00);

    // hdr 11 (len 4, addr 1) with only 3 payload bytes, parity 11^01^02^03 = 11
    send_pkt(8'h11, 32'h0003_0201, 3, 8'h11);
    chk("p3_len_err", {7'd0, bus.len_err}, 8'h01);
    chk("p3_err", {7'd0, bus.err}, 8'h00);
    chk("p3_err_count", bus.err_count, 8'h02);

    // hdr 09 (len 2): fifo_full during A5, drained by laf; parity 09^5A^A5 = F6
    drive(1, 0, 0, 0, 0, 0, 1, 8'h09, 0);
    chk("p4_len_err_clr", {7'd0, bus.len_err}, 8'h00);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h5A, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h5A, 0);
    chk("p4_dout_b0", bus.dout, 8'h5A);
    drive(0, 0, 1, 0, 0, 0, 1, 8'hA5, 1);
    chk("p4_dout_hold", bus.dout, 8'h5A);
    drive(0, 0, 0, 0, 1, 0, 1, 8'hA5, 0);
    chk("p4_dout_full", bus.dout, 8'h5A);
    drive(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0);
    chk("p4_dout_laf", bus.dout, 8'hA5);
    chk("p4_pd_laf", {7'd0, bus.parity_done}, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 0, 8'hF6, 0);
    chk("p4_dout_par", bus.dout, 8'hF6);
    chk("p4_pd", {7'd0, bus.parity_done}, 8'h01);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    chk("p4_err", {7'd0, bus.err}, 8'h00);
    chk("p4_len_err", {7'd0, bus.len_err}, 8'h00);
    idle();
    chk("p4_err_count", bus.err_count, 8'h02);

    // hdr 05 (len 1): pkt_valid drops while fifo_full; parity 05^3C = 39
    drive(1, 0, 0, 0, 0, 0, 1, 8'h05, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h3C, 0);
    chk("p5_dout_hdr", bus.dout, 8'h05);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h3C, 0);
    chk("p5_dout_b0", bus.dout, 8'h3C);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h39, 1);
    chk("p5_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
    chk("p5_pd_blocked", {7'd0, bus.parity_done}, 8'h00);
    chk("p5_dout_hold", bus.dout, 8'h3C);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h39, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    chk("p5_pd_laf", {7'd0, bus.parity_done}, 8'h01);
    chk("p5_dout_laf", bus.dout, 8'h39);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    chk("p5_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);
    chk("p5_err", {7'd0, bus.err}, 8'h00);
    chk("p5_len_err", {7'd0, bus.len_err}, 8'h00);
    idle();

    // Header with addr 2'b11 must not replace the stored header (05)
    drive(1, 0, 0, 0, 0, 0, 1, 8'hFF, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    chk("addr3_hdr_kept", bus.dout, 8'h05);
    idle();

    // Bad-parity packets drive err_count to saturation (starts at 2)
    for (int k = 0; k < 253; k++)
      send_pkt(8'h05, 32'h0000_003C, 1, 8'h00);
    chk("sat_reach", bus.err_count, 8'hFF);
    for (int k = 0; k < 3; k++)
      send_pkt(8'h05, 32'h0000_003C, 1, 8'h00);
    chk("sat_hold", bus.err_count, 8'hFF);
    chk("sat_err", {7'd0, bus.err}, 8'h01);

    // Reset mid-payload clears everything without waiting for a clock edge
    drive(1, 0, 0, 0, 0, 0, 1, 8'h0D, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h11, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h11, 0);
    chk("mid_dout_pre", bus.dout, 8'h11);
    #2 rst = 1'b1;
    #1;
    chk("mid_dout", bus.dout, 8'h00);
    chk("mid_err_count", bus.err_count, 8'h00);
    chk("mid_flags", {3'd0, bus.parity_done, bus.low_packet_valid, bus.err,
                      bus.len_err, 1'b0}, 8'h00);
    #2 rst = 1'b0;
    idle();

    // First packet after reset is processed normally
    send_pkt(8'h0D, 32'h0033_2211, 3, 8'h0D);
    chk("post_dout", bus.dout, 8'h0D);
    chk("post_pd", {7'd0, bus.parity_done}, 8'h01);
    chk("post_err", {7'd0, bus.err}, 8'h00);
    chk("post_len_err", {7'd0, bus.len_err}, 8'h00);
    chk("post_err_count", bus.err_count, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
